// File: rtl/pwm_deadtime_core.sv
// Complementary PWM gate pair with programmable dead time and period-aligned
// shadow registers, so register writes take effect only at period boundaries.
module pwm_deadtime_core #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DT_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_enable,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic [DT_W-1:0]  cfg_deadtime,
    input  logic             cfg_update,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             period_tick,
    output logic             update_pending,
    output logic [CNT_W-1:0] cnt_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        H_ON  = 3'd1,
        DT_HL = 3'd2,
        L_ON  = 3'd3,
        DT_LH = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] per_s, duty_s;
    logic [DT_W-1:0]  dt_s;
    logic [DT_W-1:0]  dt_cnt, dt_cnt_d;
    logic             pending_d;
    logic             tick_d;
    logic             load;
    logic             wrap;
    logic             raw;

    assign wrap    = (cnt == per_s);
    assign raw     = (cnt < duty_s);
    assign cnt_out = cnt;

    // Next-state, counter and shadow-load decisions
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        dt_cnt_d  = dt_cnt;
        pending_d = update_pending;
        tick_d    = 1'b0;
        load      = 1'b0;
        if (state == IDLE) begin
            cnt_d     = '0;
            pending_d = 1'b0;
            if (cfg_enable) begin
                load     = 1'b1;
                dt_cnt_d = cfg_deadtime;
                state_d  = (cfg_duty != '0) ? DT_LH : DT_HL;
            end
        end else if (!cfg_enable) begin
            state_d   = IDLE;
            cnt_d     = '0;
            pending_d = 1'b0;
        end else begin
            cnt_d  = wrap ? '0 : cnt + CNT_W'(1);
            tick_d = wrap;
            if (wrap && (update_pending || cfg_update)) begin
                load      = 1'b1;
                pending_d = 1'b0;
            end else begin
                pending_d = update_pending | cfg_update;
            end
            unique case (state)
                H_ON: begin
                    if (!raw) begin
                        state_d  = DT_HL;
                        dt_cnt_d = dt_s;
                    end
                end
                L_ON: begin
                    if (raw) begin
                        state_d  = DT_LH;
                        dt_cnt_d = dt_s;
                    end
                end
                DT_HL: begin
                    if (raw) begin
                        state_d  = DT_LH;
                        dt_cnt_d = dt_s;
                    end else if (dt_cnt <= DT_W'(1)) begin
                        state_d = L_ON;
                    end else begin
                        dt_cnt_d = dt_cnt - DT_W'(1);
                    end
                end
                DT_LH: begin
                    if (!raw) begin
                        state_d  = DT_HL;
                        dt_cnt_d = dt_s;
                    end else if (dt_cnt <= DT_W'(1)) begin
                        state_d = H_ON;
                    end else begin
                        dt_cnt_d = dt_cnt - DT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counters, shadows; gates decoded from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            dt_cnt         <= '0;
            per_s          <= '0;
            duty_s         <= '0;
            dt_s           <= '0;
            update_pending <= 1'b0;
            period_tick    <= 1'b0;
            pwm_h          <= 1'b0;
            pwm_l          <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            dt_cnt         <= dt_cnt_d;
            update_pending <= pending_d;
            period_tick    <= tick_d;
            pwm_h          <= (state_d == H_ON);
            pwm_l          <= (state_d == L_ON);
            if (load) begin
                per_s  <= cfg_period;
                duty_s <= cfg_duty;
                dt_s   <= cfg_deadtime;
            end
        end
    end

endmodule

// File: doc/pwm_deadtime_core.md
Name: pwm_deadtime_core

Overview:
- Timing core behind the CustomIP_PWM AXI4-Lite register file.
- Consumes the enable, period, duty and dead-time register values.
- Generates a complementary high-side/low-side gate pair with programmable dead time for the EV inverter leg.
- Register values are double-buffered in shadow registers and take effect only at period boundaries, so AXI writes never produce glitched pulses.

Parameters:
- CNT_W, 16, width of the period/duty counter and registers.
- DT_W, 8, width of the dead-time register (dead time in clock cycles).

Ports:
- clock  in  1  system clock (same clock as the AXI slave).
- reset  in  1  synchronous, active-high reset.
- cfg_enable  in  1  run/stop bit from control register.
- cfg_period  in  CNT_W  period minus one (counter terminal value).
- cfg_duty  in  CNT_W  high-side on-count per period.
- cfg_deadtime  in  DT_W  dead-time cycles.
- cfg_update  in  1  one-cycle pulse on any write to period/duty/deadtime registers.
- pwm_h  out  1  high-side gate drive.
- pwm_l  out  1  low-side gate drive.
- period_tick  out  1  one-cycle pulse at counter terminal value.
- update_pending  out  1  shadow load requested but not yet applied (readable status).
- cnt_out  out  CNT_W  current counter value (status).

Behaviour:
- Reset:
  - pwm_h=0, pwm_l=0, period_tick=0, update_pending=0, cnt_out=0.
  - Shadows per_s/duty_s/dt_s=0; FSM=IDLE.
  - Reset mid-operation forces this state on the next edge; both gates low immediately after.
- Shadow load, all three shadows together:
  - Loads when (cfg_enable & FSM==IDLE) or (running & cnt==per_s & (update_pending|cfg_update)).
  - update_pending sets on cfg_update, clears on load.
  - If cfg_update coincides with a load edge, current cfg values are loaded and pending is 0 afterward.
- Counter:
  - While running: cnt 0..per_s, then wraps to 0.
  - per_s=0: cnt stays 0, period_tick every cycle.
  - period_tick is registered: high in the cycle after cnt==per_s was sampled.
- Raw PWM: raw = (cnt < duty_s), unsigned compare.
  - duty_s=0: raw always 0.
  - duty_s>per_s: raw always 1.
- FSM states: IDLE, H_ON, DT_HL, L_ON, DT_LH. Outputs are registered from next state.
  - IDLE: both gates 0. On cfg_enable=1, load shadows, cnt<=0, go to DT_LH (low-to-high transition) if duty_s>0, else DT_HL. This guarantees a full dead interval after start.
  - H_ON: pwm_h=1, pwm_l=0. raw=0 -> DT_HL with dt counter<=dt_s.
  - DT_HL: both 0. Counter decrements; when it reaches 0 with raw=0 -> L_ON. If raw returns to 1 -> DT_LH with counter reloaded to dt_s.
  - L_ON: pwm_l=1, pwm_h=0. raw=1 -> DT_LH with counter<=dt_s.
  - DT_LH: both 0. Symmetric to DT_HL; exits to H_ON.
  - dt_s=0: dead states last exactly 1 cycle (both gates low for one cycle). Gates never overlap.
- Latency: raw edge at cycle N -> active gate falls at N+1 -> opposite gate rises at N+1+max(dt_s,1).
- Invariant: pwm_h & pwm_l == 0 in every cycle, including reset, disable and shadow loads.
- Disable:
  - cfg_enable=0 while running -> next edge FSM=IDLE, both gates 0, cnt<=0.
  - update_pending is cleared.
  - Re-enable performs a fresh shadow load.
- Pulses shorter than dead time: the gate for that pulse never turns on.

Test Plan:
- period=9, duty=4, dt=0, enable -> period_tick every 10 cycles. pwm_h high 3 cycles, pwm_l high 5 cycles per period, 1-cycle gaps. cnt_out wraps 9->0.
- period=9, duty=4, dt=2 -> pwm_h high 2 cycles, pwm_l high 4 cycles, two 2-cycle gaps. pwm_h & pwm_l never 1 together.
- Running period=9, duty=4; at cnt=3 write duty=7 with cfg_update -> update_pending=1 until wrap. First period keeps duty 4; next period has raw high 7 cycles; pending=0 after wrap.
- duty=0 -> pwm_h stays 0, pwm_l continuous after the initial dead interval. duty=12 with period=9 -> pwm_h continuous, pwm_l stays 0.
- dt=5, duty=2, period=19 -> raw pulse (2 cycles) shorter than dead time: pwm_h never asserts, pwm_l drops for 2+5 cycles each period.
- Assert reset at cnt=6 with pwm_h=1 -> next cycle all outputs 0, cnt_out=0. Deassert reset, enable -> restart from DT_LH with the full dead interval.
